// File: rtl/debug_vjtag_scan_driver.sv
// Virtual-JTAG initiator: runs one UIR/CDR/SDR*N/UDR/RTI sequence per command and
// returns the DR bits shifted out of the debug slave together with the sampled IR status.
module debug_vjtag_scan_driver #(
    parameter int DR_WIDTH = 38,
    parameter int IR_WIDTH = 2,
    parameter int TCK_DIV  = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [IR_WIDTH-1:0] cmd_ir,
    input  logic [DR_WIDTH-1:0] cmd_dr,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DR_WIDTH-1:0] rsp_dr,
    output logic [IR_WIDTH-1:0] rsp_ir_out,
    output logic                vj_tck,
    output logic                vj_tdi,
    input  logic                vj_tdo,
    output logic [IR_WIDTH-1:0] vj_ir_in,
    input  logic [IR_WIDTH-1:0] vj_ir_out,
    output logic                vj_uir,
    output logic                vj_cdr,
    output logic                vj_sdr,
    output logic                vj_udr,
    output logic                vj_rti
);

    localparam int DIV_W = $clog2(2 * TCK_DIV);
    localparam int BIT_W = $clog2(DR_WIDTH + 1);

    localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(TCK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(2 * TCK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DR_WIDTH - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_UIR   = 3'd1;
    localparam logic [2:0] S_CDR   = 3'd2;
    localparam logic [2:0] S_SHIFT = 3'd3;
    localparam logic [2:0] S_UDR   = 3'd4;
    localparam logic [2:0] S_RTI   = 3'd5;
    localparam logic [2:0] S_RESP  = 3'd6;

    logic [2:0]          state_q, state_d;
    logic [DIV_W-1:0]    div_q, div_d;
    logic [BIT_W-1:0]    bit_q, bit_d;
    logic                tck_q, tck_d;
    logic                tdi_q, tdi_d;
    logic [IR_WIDTH-1:0] ir_in_q, ir_in_d;
    logic [IR_WIDTH-1:0] irout_q, irout_d;
    logic [DR_WIDTH-1:0] rx_q, rx_d;
    logic [DR_WIDTH-1:0] tx_q, tx_d;
    logic [DR_WIDTH:0]   rx_shift;

    // New tdo bit enters at the MSB so the first captured bit ends up in rsp_dr[0].
    assign rx_shift = {vj_tdo, rx_q};

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        bit_d   = bit_q;
        tck_d   = tck_q;
        tdi_d   = tdi_q;
        ir_in_d = ir_in_q;
        irout_d = irout_q;
        rx_d    = rx_q;
        tx_d    = tx_q;
        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    state_d = S_UIR;
                    div_d   = '0;
                    bit_d   = '0;
                    tck_d   = 1'b0;
                    tdi_d   = 1'b0;
                    ir_in_d = cmd_ir;
                    rx_d    = '0;
                    tx_d    = cmd_dr;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                div_d = div_q + DIV_W'(1);
                // Rising tck: the slave's outputs are sampled on this same clk edge.
                if (div_q == DIV_HALF) begin
                    tck_d = 1'b1;
                    if (state_q == S_UIR) begin
                        irout_d = vj_ir_out;
                    end
                    if (state_q == S_SHIFT) begin
                        rx_d = rx_shift[DR_WIDTH:1];
                    end
                end
                // Falling tck closes the period; every strobe/tdi change happens here.
                if (div_q == DIV_LAST) begin
                    div_d = '0;
                    tck_d = 1'b0;
                    case (state_q)
                        S_UIR: state_d = S_CDR;
                        S_CDR: begin
                            state_d = S_SHIFT;
                            bit_d   = '0;
                            tdi_d   = tx_q[0];
                            tx_d    = tx_q >> 1;
                        end
                        S_SHIFT: begin
                            if (bit_q == BIT_LAST) begin
                                state_d = S_UDR;
                                tdi_d   = 1'b0;
                            end else begin
                                bit_d = bit_q + BIT_W'(1);
                                tdi_d = tx_q[0];
                                tx_d  = tx_q >> 1;
                            end
                        end
                        S_UDR: state_d = S_RTI;
                        S_RTI: begin
                            state_d = S_RESP;
                            ir_in_d = '0;
                        end
                        default: begin
                            state_d = S_IDLE;
                            ir_in_d = '0;
                        end
                    endcase
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            div_q   <= '0;
            bit_q   <= '0;
            tck_q   <= 1'b0;
            tdi_q   <= 1'b0;
            ir_in_q <= '0;
            irout_q <= '0;
            rx_q    <= '0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            tck_q   <= tck_d;
            tdi_q   <= tdi_d;
            ir_in_q <= ir_in_d;
            irout_q <= irout_d;
            rx_q    <= rx_d;
        end
    end

    // Outgoing shift data is only meaningful inside a scan, so it carries no reset.
    always_ff @(posedge clk) begin
        tx_q <= tx_d;
    end

    assign cmd_ready  = (state_q == S_IDLE);
    assign rsp_valid  = (state_q == S_RESP);
    assign rsp_dr     = rx_q;
    assign rsp_ir_out = irout_q;
    assign vj_tck     = tck_q;
    assign vj_tdi     = tdi_q;
    assign vj_ir_in   = ir_in_q;
    assign vj_uir     = (state_q == S_UIR);
    assign vj_cdr     = (state_q == S_CDR);
    assign vj_sdr     = (state_q == S_SHIFT);
    assign vj_udr     = (state_q == S_UDR);
    assign vj_rti     = (state_q == S_RTI);

endmodule

// File: tb/tb_debug_vjtag_scan_driver.sv
// Scoreboard bench for debug_vjtag_scan_driver: a default-sized instance and a
// DR_WIDTH=4 / TCK_DIV=1 instance, each with its own expected-response queue and monitor.
module tb_debug_vjtag_scan_driver;

    typedef struct {
        logic [37:0] dr;
        logic [1:0]  ir;
        int          acc;
        int          lat;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // Instance A: default parameters
    logic        cmd_valid_a, cmd_ready_a, rsp_valid_a, rsp_ready_a;
    logic [1:0]  cmd_ir_a, rsp_ir_out_a, vj_ir_in_a, vj_ir_out_a;
    logic [37:0] cmd_dr_a, rsp_dr_a;
    logic        vj_tck_a, vj_tdi_a, vj_tdo_a;
    logic        vj_uir_a, vj_cdr_a, vj_sdr_a, vj_udr_a, vj_rti_a;
    logic        loop_a, tdo_tie_a;
    assign vj_tdo_a = loop_a ? vj_tdi_a : tdo_tie_a;

    debug_vjtag_scan_driver u_dut_a (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid_a), .cmd_ready(cmd_ready_a),
        .cmd_ir(cmd_ir_a), .cmd_dr(cmd_dr_a),
        .rsp_valid(rsp_valid_a), .rsp_ready(rsp_ready_a),
        .rsp_dr(rsp_dr_a), .rsp_ir_out(rsp_ir_out_a),
        .vj_tck(vj_tck_a), .vj_tdi(vj_tdi_a), .vj_tdo(vj_tdo_a),
        .vj_ir_in(vj_ir_in_a), .vj_ir_out(vj_ir_out_a),
        .vj_uir(vj_uir_a), .vj_cdr(vj_cdr_a), .vj_sdr(vj_sdr_a),
        .vj_udr(vj_udr_a), .vj_rti(vj_rti_a)
    );

    // Instance B: short register, fastest tck, permanent loopback
    logic        cmd_valid_b, cmd_ready_b, rsp_valid_b, rsp_ready_b;
    logic [1:0]  cmd_ir_b, rsp_ir_out_b, vj_ir_in_b, vj_ir_out_b;
    logic [3:0]  cmd_dr_b, rsp_dr_b;
    logic        vj_tck_b, vj_tdi_b, vj_tdo_b;
    logic        vj_uir_b, vj_cdr_b, vj_sdr_b, vj_udr_b, vj_rti_b;
    assign vj_tdo_b = vj_tdi_b;

    debug_vjtag_scan_driver #(.DR_WIDTH(4), .IR_WIDTH(2), .TCK_DIV(1)) u_dut_b (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid_b), .cmd_ready(cmd_ready_b),
        .cmd_ir(cmd_ir_b), .cmd_dr(cmd_dr_b),
        .rsp_valid(rsp_valid_b), .rsp_ready(rsp_ready_b),
        .rsp_dr(rsp_dr_b), .rsp_ir_out(rsp_ir_out_b),
        .vj_tck(vj_tck_b), .vj_tdi(vj_tdi_b), .vj_tdo(vj_tdo_b),
        .vj_ir_in(vj_ir_in_b), .vj_ir_out(vj_ir_out_b),
        .vj_uir(vj_uir_b), .vj_cdr(vj_cdr_b), .vj_sdr(vj_sdr_b),
        .vj_udr(vj_udr_b), .vj_rti(vj_rti_b)
    );

    exp_t qa[$];
    exp_t qb[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [50:0] pack_a();
        return {cmd_ready_a, rsp_valid_a, rsp_dr_a, rsp_ir_out_a, vj_tck_a, vj_tdi_a,
                vj_ir_in_a, vj_uir_a, vj_cdr_a, vj_sdr_a, vj_udr_a, vj_rti_a};
    endfunction

    // Monitor A: pops the scoreboard on every response handshake
    int first_a = 0;
    initial begin
        logic prev_va;
        exp_t e;
        prev_va = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_va = 1'b0;
            end else begin
                if (rsp_valid_a && !prev_va) first_a = cyc;
                prev_va = rsp_valid_a;
                if (rsp_valid_a && rsp_ready_a) begin
                    if (qa.size() == 0) begin
                        check("unexpected_rsp_a", 64'd1, 64'd0);
                    end else begin
                        e = qa.pop_front();
                        check("rsp_dr_a", rsp_dr_a, e.dr);
                        check("rsp_ir_out_a", rsp_ir_out_a, e.ir);
                        check("rsp_latency_a", first_a - e.acc, e.lat);
                    end
                end
            end
        end
    end

    // Monitor B
    int first_b = 0;
    initial begin
        logic prev_vb;
        exp_t e;
        prev_vb = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_vb = 1'b0;
            end else begin
                if (rsp_valid_b && !prev_vb) first_b = cyc;
                prev_vb = rsp_valid_b;
                if (rsp_valid_b && rsp_ready_b) begin
                    if (qb.size() == 0) begin
                        check("unexpected_rsp_b", 64'd1, 64'd0);
                    end else begin
                        e = qb.pop_front();
                        check("rsp_dr_b", rsp_dr_b, e.dr[3:0]);
                        check("rsp_ir_out_b", rsp_ir_out_b, e.ir);
                        check("rsp_latency_b", first_b - e.acc, e.lat);
                    end
                end
            end
        end
    end

    // TAP activity observers
    logic [1:0] exp_ir_in;
    int rise_tot_a = 0, rise_uir = 0, rise_cdr = 0, rise_sdr = 0, rise_udr = 0, rise_rti = 0;
    int onehot_bad = 0, ir_bad = 0, idle_bad = 0;
    initial begin
        logic prev_tck, any;
        prev_tck = 1'b0;
        forever begin
            @(negedge clk);
            any = vj_uir_a | vj_cdr_a | vj_sdr_a | vj_udr_a | vj_rti_a;
            if ($countones({vj_uir_a, vj_cdr_a, vj_sdr_a, vj_udr_a, vj_rti_a}) > 1) onehot_bad++;
            if (any && vj_ir_in_a !== exp_ir_in) ir_bad++;
            if (!any && (vj_ir_in_a !== 2'b00 || vj_tck_a !== 1'b0 || vj_tdi_a !== 1'b0)) idle_bad++;
            if (vj_tck_a && !prev_tck) begin
                rise_tot_a++;
                if (vj_uir_a) rise_uir++;
                if (vj_cdr_a) rise_cdr++;
                if (vj_sdr_a) rise_sdr++;
                if (vj_udr_a) rise_udr++;
                if (vj_rti_a) rise_rti++;
            end
            prev_tck = vj_tck_a;
        end
    end

    int rise_tot_b = 0, gap_bad_b = 0;
    initial begin
        logic prev_tck, prev_sdr_rise;
        int last_rise;
        prev_tck = 1'b0;
        prev_sdr_rise = 1'b0;
        last_rise = 0;
        forever begin
            @(negedge clk);
            if (vj_tck_b && !prev_tck) begin
                rise_tot_b++;
                if (vj_sdr_b) begin
                    if (prev_sdr_rise && (cyc - last_rise) != 2) gap_bad_b++;
                    prev_sdr_rise = 1'b1;
                end else begin
                    prev_sdr_rise = 1'b0;
                end
                last_rise = cyc;
            end
            prev_tck = vj_tck_b;
        end
    end

    task automatic send_a(input logic [1:0] ir, input logic [37:0] dr, input logic [37:0] edr,
                          input logic [1:0] eir, input bit expect_rsp);
        int n;
        exp_t e;
        n = 0;
        cmd_ir_a = ir;
        cmd_dr_a = dr;
        cmd_valid_a = 1'b1;
        exp_ir_in = ir;
        while (!cmd_ready_a && n < 500) begin
            step();
            n++;
        end
        if (!cmd_ready_a) begin
            check("cmd_accept_timeout_a", 64'd1, 64'd0);
        end else if (expect_rsp) begin
            e.dr = edr; e.ir = eir; e.acc = cyc + 1; e.lat = 168;
            qa.push_back(e);
        end
        step();
        cmd_valid_a = 1'b0;
    endtask

    task automatic wait_a();
        int n;
        n = 0;
        while (qa.size() != 0 && n < 600) begin
            step();
            n++;
        end
        if (qa.size() != 0) check("rsp_timeout_a", 64'd1, 64'd0);
        step();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int bad, n;
        exp_t e;
        reset = 1'b1;
        cmd_valid_a = 0; cmd_ir_a = 0; cmd_dr_a = 0; rsp_ready_a = 1;
        vj_ir_out_a = 0; loop_a = 1; tdo_tie_a = 0; exp_ir_in = 0;
        cmd_valid_b = 0; cmd_ir_b = 0; cmd_dr_b = 0; rsp_ready_b = 1; vj_ir_out_b = 2'b01;
        repeat (3) step();
        check("reset_state_a", pack_a(), {1'b1, 50'd0});
        check("reset_state_b", {cmd_ready_b, rsp_valid_b, rsp_dr_b, vj_tck_b}, 7'b1000000);
        reset = 1'b0;

        // 1: idle for 50 cycles, nothing moves
        bad = 0;
        repeat (50) begin
            step();
            if (pack_a() !== {1'b1, 50'd0}) bad++;
        end
        check("idle_outputs", bad, 0);
        check("idle_no_tck", rise_tot_a, 0);

        // 2: loopback pattern, per-state tck edge counts
        rise_uir = 0; rise_cdr = 0; rise_sdr = 0; rise_udr = 0; rise_rti = 0;
        loop_a = 1; vj_ir_out_a = 2'b10;
        send_a(2'b10, 38'h2A_5A5A_5A5A, 38'h2A_5A5A_5A5A, 2'b10, 1);
        wait_a();
        check("sdr_tck_edges", rise_sdr, 38);
        check("uir_tck_edges", rise_uir, 1);
        check("cdr_tck_edges", rise_cdr, 1);
        check("udr_tck_edges", rise_udr, 1);
        check("rti_tck_edges", rise_rti, 1);

        // 3: tdo tied high, IR status 01
        loop_a = 0; tdo_tie_a = 1; vj_ir_out_a = 2'b01;
        send_a(2'b10, 38'h00_1234_0000, 38'h3F_FFFF_FFFF, 2'b01, 1);
        wait_a();
        check("ir_in_held_uir_to_rti", ir_bad, 0);

        // 4: stalled response, second command must wait for the handshake
        loop_a = 1; vj_ir_out_a = 2'b11; rsp_ready_a = 0;
        send_a(2'b01, 38'h01_2345_6789, 38'h01_2345_6789, 2'b11, 1);
        n = 0;
        while (!rsp_valid_a && n < 400) begin
            step();
            n++;
        end
        check("stall_rsp_seen", rsp_valid_a, 1);
        cmd_ir_a = 2'b11; cmd_dr_a = 38'h3C_0F0F_00FF; cmd_valid_a = 1; exp_ir_in = 2'b11;
        bad = 0;
        repeat (20) begin
            if (!rsp_valid_a || cmd_ready_a || rsp_dr_a !== 38'h01_2345_6789 || rsp_ir_out_a !== 2'b11) bad++;
            step();
        end
        check("stall_hold", bad, 0);
        rsp_ready_a = 1;
        e.dr = 38'h3C_0F0F_00FF; e.ir = 2'b11; e.acc = cyc + 2; e.lat = 168;
        qa.push_back(e);
        step();
        check("ready_after_handshake", {cmd_ready_a, rsp_valid_a}, 2'b10);
        step();
        check("accepted_after_handshake", cmd_ready_a, 0);
        cmd_valid_a = 0;
        wait_a();

        // 5: reset during SHIFT bit 17 aborts with no response
        rise_sdr = 0;
        send_a(2'b10, 38'h15_A5A5_A5A5, 38'h0, 2'b00, 0);
        n = 0;
        while (rise_sdr < 17 && n < 300) begin
            step();
            n++;
        end
        check("reach_shift_bit16", rise_sdr, 17);
        step();
        step();
        reset = 1'b1;
        step();
        check("abort_reset_state", pack_a(), {1'b1, 50'd0});
        reset = 1'b0;
        bad = 0;
        repeat (200) begin
            step();
            if (rsp_valid_a) bad++;
        end
        check("no_rsp_after_abort", bad, 0);
        vj_ir_out_a = 2'b10;
        send_a(2'b01, 38'h15_A5A5_A5A5, 38'h15_A5A5_A5A5, 2'b10, 1);
        wait_a();

        // 6: small instance, 2-clk tck period
        rise_tot_b = 0; gap_bad_b = 0;
        cmd_ir_b = 2'b10; cmd_dr_b = 4'b1011; cmd_valid_b = 1;
        n = 0;
        while (!cmd_ready_b && n < 50) begin
            step();
            n++;
        end
        e.dr = 38'h0B; e.ir = 2'b01; e.acc = cyc + 1; e.lat = 16;
        qb.push_back(e);
        step();
        cmd_valid_b = 0;
        n = 0;
        while (qb.size() != 0 && n < 100) begin
            step();
            n++;
        end
        check("rsp_drained_b", qb.size(), 0);
        check("tck_edges_b", rise_tot_b, 8);
        check("tck_period_b", gap_bad_b, 0);

        step();
        check("queue_a_empty", qa.size(), 0);
        check("strobes_onehot", onehot_bad, 0);
        check("idle_quiet", idle_bad, 0);
        check("ir_in_final", ir_bad, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
